// File: rtl/usrt_rx_shifter.sv
// USRT receive front end: synchronizes the external serial clock and data, deframes
// start/8 data/[parity]/stop and pushes each good byte into the Rx data register.
module usrt_rx_shifter #(
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0
) (
  input  logic       i_Pclk,
  input  logic       i_Reset,
  input  logic       i_RxEn,
  input  logic       i_SClk,
  input  logic       i_RxD,
  input  logic       i_Full,
  output logic       o_Push,
  output logic [7:0] o_Data,
  output logic       o_FrameErr,
  output logic       o_ParityErr,
  output logic       o_Overrun,
  output logic       o_Busy
);

  // state  | meaning
  // IDLE   | waiting for a start bit (RxD low at an SClk rise)
  // DATA   | shifting in data bits 0..7, LSB first
  // PARITY | sampling the parity bit (only when PARITY_EN=1)
  // STOP   | sampling the stop bit, then deliver byte or flag an error
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] rxd_sync_q;
  logic                   sclk_prev_q;
  logic                   strobe;
  logic                   rxd_s;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [7:0] shreg_q;
  logic [7:0] shreg_d;
  logic       perr_q;
  logic       perr_d;
  logic [7:0] data_q;
  logic       push_q;
  logic       ferr_q;
  logic       perr_pulse_q;
  logic       ovr_q;

  // Both lines see the same number of stages so data stays aligned with the clock edge.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      sclk_sync_q <= '1;
      rxd_sync_q  <= '1;
      sclk_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SClk};
      rxd_sync_q  <= {rxd_sync_q[SYNC_STAGES-2:0], i_RxD};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe  = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign rxd_s   = rxd_sync_q[SYNC_STAGES-1];
  assign shreg_d = {rxd_s, shreg_q[7:1]};
  assign perr_d  = ((^shreg_q) ^ rxd_s) != PAR_ODD;

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      shreg_q      <= 8'h00;
      perr_q       <= 1'b0;
      data_q       <= 8'h00;
      push_q       <= 1'b0;
      ferr_q       <= 1'b0;
      perr_pulse_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      ferr_q       <= 1'b0;
      perr_pulse_q <= 1'b0;
      ovr_q        <= 1'b0;
      if (!i_RxEn) begin
        state_q <= S_IDLE;
        cnt_q   <= 3'd0;
        perr_q  <= 1'b0;
      end else if (strobe) begin
        case (state_q)
          S_IDLE: begin
            if (!rxd_s) begin
              state_q <= S_DATA;
              cnt_q   <= 3'd0;
              perr_q  <= 1'b0;
            end
          end
          S_DATA: begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_q <= PAR_EN ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            perr_q  <= perr_d;
            state_q <= S_STOP;
          end
          S_STOP: begin
            // A bad stop bit masks any parity error on the same frame.
            if (!rxd_s) begin
              ferr_q <= 1'b1;
            end else if (perr_q) begin
              perr_pulse_q <= 1'b1;
            end else begin
              data_q <= shreg_q;
              push_q <= 1'b1;
              ovr_q  <= i_Full;
            end
            perr_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_Push      = push_q;
  assign o_Data      = data_q;
  assign o_FrameErr  = ferr_q;
  assign o_ParityErr = perr_pulse_q;
  assign o_Overrun   = ovr_q;
  assign o_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_usrt_rx_shifter.sv
// Bench for usrt_rx_shifter: three instances (no parity, even, odd) checked against a
// frame-level model of the expected outcome of each serial frame.
module tb_usrt_rx_shifter;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxen;
  logic       sclk;
  logic       full;
  logic [2:0] rxd;

  logic [2:0] push_w, ferr_w, perr_w, ovr_w, busy_w;
  logic [7:0] data_w [3];

  always #5 clk = ~clk;

  usrt_rx_shifter #(.SYNC_STAGES(SYNC), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .i_Pclk(clk), .i_Reset(rst), .i_RxEn(rxen), .i_SClk(sclk), .i_RxD(rxd[0]), .i_Full(full),
    .o_Push(push_w[0]), .o_Data(data_w[0]), .o_FrameErr(ferr_w[0]), .o_ParityErr(perr_w[0]),
    .o_Overrun(ovr_w[0]), .o_Busy(busy_w[0]));

  usrt_rx_shifter #(.SYNC_STAGES(SYNC), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .i_Pclk(clk), .i_Reset(rst), .i_RxEn(rxen), .i_SClk(sclk), .i_RxD(rxd[1]), .i_Full(full),
    .o_Push(push_w[1]), .o_Data(data_w[1]), .o_FrameErr(ferr_w[1]), .o_ParityErr(perr_w[1]),
    .o_Overrun(ovr_w[1]), .o_Busy(busy_w[1]));

  usrt_rx_shifter #(.SYNC_STAGES(SYNC), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .i_Pclk(clk), .i_Reset(rst), .i_RxEn(rxen), .i_SClk(sclk), .i_RxD(rxd[2]), .i_Full(full),
    .o_Push(push_w[2]), .o_Data(data_w[2]), .o_FrameErr(ferr_w[2]), .o_ParityErr(perr_w[2]),
    .o_Overrun(ovr_w[2]), .o_Busy(busy_w[2]));

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int half = 4;
  int last_rise = 0;

  int n_push [3] = '{0, 0, 0};
  int n_ferr [3] = '{0, 0, 0};
  int n_perr [3] = '{0, 0, 0};
  int n_ovr  [3] = '{0, 0, 0};
  int push_cyc [3] = '{0, 0, 0};
  int n_viol = 0;
  logic [2:0] pp = '0, fp = '0, ep = '0;
  logic [7:0] dprev [3] = '{8'h00, 8'h00, 8'h00};

  int s_push, s_ferr, s_perr, s_ovr;
  logic [7:0] exp_data [3];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counting plus invariant watch: single-cycle pulses, overrun only with push,
  // o_Data moves only with push (outside reset).
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push_w[i]) begin
        n_push[i]   <= n_push[i] + 1;
        push_cyc[i] <= cyc;
      end
      if (ferr_w[i]) n_ferr[i] <= n_ferr[i] + 1;
      if (perr_w[i]) n_perr[i] <= n_perr[i] + 1;
      if (ovr_w[i])  n_ovr[i]  <= n_ovr[i] + 1;
      if ((push_w[i] && pp[i]) || (ferr_w[i] && fp[i]) || (perr_w[i] && ep[i]) ||
          (ovr_w[i] && !push_w[i]) ||
          (data_w[i] !== dprev[i] && !push_w[i] && !rst))
        n_viol <= n_viol + 1;
      pp[i]    <= push_w[i];
      fp[i]    <= ferr_w[i];
      ep[i]    <= perr_w[i];
      dprev[i] <= data_w[i];
    end
  end

  task automatic sbit(input int d, input logic b);
    rxd[d] = b;
    sclk = 1'b0;
    repeat (half) @(negedge clk);
    sclk = 1'b1;
    last_rise = cyc;
    repeat (half) @(negedge clk);
  endtask

  task automatic send(input int d, input logic [7:0] v, input logic par, input logic stop);
    sbit(d, 1'b0);
    for (int i = 0; i < 8; i++) sbit(d, v[i]);
    if (d != 0) sbit(d, par);
    sbit(d, stop);
    rxd[d] = 1'b1;
  endtask

  task automatic snap(input int d);
    s_push = n_push[d];
    s_ferr = n_ferr[d];
    s_perr = n_perr[d];
    s_ovr  = n_ovr[d];
  endtask

  task automatic expect_frame(input int d, input string tag, input int e_push, input int e_ferr,
                              input int e_perr, input int e_ovr, input logic [7:0] e_data);
    repeat (8) @(negedge clk);
    chk({tag, "_push"}, n_push[d] - s_push, e_push);
    chk({tag, "_ferr"}, n_ferr[d] - s_ferr, e_ferr);
    chk({tag, "_perr"}, n_perr[d] - s_perr, e_perr);
    chk({tag, "_ovr"},  n_ovr[d]  - s_ovr,  e_ovr);
    chk({tag, "_data"}, data_w[d], e_data);
    chk({tag, "_idle"}, busy_w[d], 0);
  endtask

  // Frame-level reference: outcome of one frame from the framing rules alone.
  function automatic logic good_parity(input int d, input logic [7:0] v);
    return (d == 2) ? ~(^v) : (^v);
  endfunction

  task automatic model_frame(input int d, input logic [7:0] v, input logic par, input logic stop,
                             input logic f, output int e_push, output int e_ferr,
                             output int e_perr, output int e_ovr);
    e_push = 0; e_ferr = 0; e_perr = 0; e_ovr = 0;
    if (!stop) e_ferr = 1;
    else if (d != 0 && par != good_parity(d, v)) e_perr = 1;
    else begin
      e_push = 1;
      e_ovr  = f ? 1 : 0;
      exp_data[d] = v;
    end
  endtask

  task automatic check_latency(input string tag, input int d);
    chk(tag, ((push_cyc[d] - last_rise) >= SYNC + 1) && ((push_cyc[d] - last_rise) <= SYNC + 2), 1);
  endtask

  task automatic check_reset(input int d);
    chk("rst_push", push_w[d], 0);
    chk("rst_data", data_w[d], 8'h00);
    chk("rst_ferr", ferr_w[d], 0);
    chk("rst_perr", perr_w[d], 0);
    chk("rst_ovr",  ovr_w[d],  0);
    chk("rst_busy", busy_w[d], 0);
  endtask

  initial begin
    int ep_, ef_, epr_, eo_;
    logic [7:0] v;
    logic par, stop, f;
    int d;

    rst = 1'b1; rxen = 1'b1; sclk = 1'b1; full = 1'b0; rxd = 3'b111;
    exp_data = '{8'h00, 8'h00, 8'h00};
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset(i);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame, latency from the stop-bit SClk rise
    snap(0); send(0, 8'hA5, 1'b0, 1'b1);
    expect_frame(0, "t1", 1, 0, 0, 0, 8'hA5);
    check_latency("t1_latency", 0);

    // Back-to-back frames, register reported full after the first
    snap(0);
    send(0, 8'h3C, 1'b0, 1'b1);
    full = 1'b1;
    send(0, 8'hC3, 1'b0, 1'b1);
    expect_frame(0, "t2", 2, 0, 0, 1, 8'hC3);
    full = 1'b0;

    // Framing error keeps previous byte, next frame still lands
    snap(0); send(0, 8'h55, 1'b0, 1'b0);
    expect_frame(0, "t3_bad", 0, 1, 0, 0, 8'hC3);
    snap(0); send(0, 8'h12, 1'b0, 1'b1);
    expect_frame(0, "t3_ok", 1, 0, 0, 0, 8'h12);

    // Parity: even instance then odd instance
    snap(1); send(1, 8'h07, 1'b1, 1'b1);
    expect_frame(1, "t4_even_good", 1, 0, 0, 0, 8'h07);
    snap(1); send(1, 8'h07, 1'b0, 1'b1);
    expect_frame(1, "t4_even_bad", 0, 0, 1, 0, 8'h07);
    snap(2); send(2, 8'h07, 1'b0, 1'b1);
    expect_frame(2, "t4_odd_good", 1, 0, 0, 0, 8'h07);
    snap(2); send(2, 8'h07, 1'b1, 1'b1);
    expect_frame(2, "t4_odd_bad", 0, 0, 1, 0, 8'h07);
    snap(2); send(2, 8'h5A, 1'b1, 1'b0);
    expect_frame(2, "t4_stop_prio", 0, 1, 0, 0, 8'h07);
    exp_data = '{8'h12, 8'h07, 8'h07};

    // Receiver disabled mid-frame
    snap(0);
    sbit(0, 1'b0);
    for (int i = 0; i < 4; i++) sbit(0, 1'b1);
    chk("t5_busy_mid", busy_w[0], 1);
    rxen = 1'b0;
    rxd[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_busy_off", busy_w[0], 0);
    for (int i = 0; i < 4; i++) sbit(0, 1'b0);
    rxen = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 8'h81, 1'b0, 1'b1);
    expect_frame(0, "t5", 1, 0, 0, 0, 8'h81);

    // Reset in the middle of a frame
    sbit(0, 1'b0);
    sbit(0, 1'b1);
    sbit(0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset(0);
    rxd[0] = 1'b1;
    rst = 1'b0;
    exp_data = '{8'h00, 8'h00, 8'h00};
    repeat (3) @(negedge clk);
    snap(0); send(0, 8'hF0, 1'b0, 1'b1);
    expect_frame(0, "t6", 1, 0, 0, 0, 8'hF0);
    exp_data[0] = 8'hF0;

    // Random frames across all three parity configurations
    for (int k = 0; k < 24; k++) begin
      d    = $urandom_range(0, 2);
      v    = 8'($urandom);
      half = $urandom_range(2, 5);
      stop = ($urandom_range(0, 4) != 0);
      par  = good_parity(d, v) ^ ($urandom_range(0, 3) == 0);
      f    = 1'($urandom_range(0, 1));
      full = f;
      snap(d);
      send(d, v, par, stop);
      model_frame(d, v, par, stop, f, ep_, ef_, epr_, eo_);
      expect_frame(d, "rnd", ep_, ef_, epr_, eo_, exp_data[d]);
      if (ep_ == 1) check_latency("rnd_latency", d);
    end
    full = 1'b0;

    chk("invariants", n_viol, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
